// File: rtl/imsic_msi_eip_ctrl_if.sv
// MSI input channel bundle: per-port {hart, file, id} payload and asynchronous valid levels.
// The payload must stay stable for as long as the matching valid level is high.
interface imsic_msi_eip_ctrl_if #(
  parameter int NR_MSI_PORTS   = 2,
  parameter int MSI_INFO_WIDTH = 13
);
  logic [NR_MSI_PORTS*MSI_INFO_WIDTH-1:0] i_msi_info;
  logic [NR_MSI_PORTS-1:0]                i_msi_info_vld;

  modport master (output i_msi_info, output i_msi_info_vld);
  modport slave  (input  i_msi_info, input  i_msi_info_vld);
endinterface

// File: rtl/imsic_msi_eip_ctrl.sv
// Multi-port MSI receive: sync + edge detect, filter, queue, then drain one MSI per cycle into eip.
// Latency is edge cycle E to eip bit at E+2; i_eip_hold stalls draining and a full queue drops MSIs (counted).
module imsic_msi_eip_ctrl #(
  parameter int NR_INTP_FILES  = 7,
  parameter int XLEN           = 64,
  parameter int NR_HARTS       = 4,
  parameter int NR_HARTS_WIDTH = 2,
  parameter int NR_SRC         = 256,
  parameter int NR_MSI_PORTS   = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  localparam int NR_SRC_WIDTH    = $clog2(NR_SRC),
  localparam int NR_REG          = (NR_SRC + XLEN - 1) / XLEN,
  localparam int INTP_FILE_WIDTH = $clog2(NR_INTP_FILES),
  localparam int MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH,
  localparam int NR_FLAT         = NR_INTP_FILES * NR_REG,
  localparam int SW_IDX_WIDTH    = $clog2(NR_FLAT),
  localparam int CNT_W           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NR_HARTS_WIDTH-1:0]     hart_id,
  imsic_msi_eip_ctrl_if.slave           msi,
  input  logic                          i_eip_hold,
  input  logic                          i_claim_vld,
  input  logic [INTP_FILE_WIDTH-1:0]    i_claim_file,
  input  logic [NR_SRC_WIDTH-1:0]       i_claim_id,
  input  logic                          i_sw_wr,
  input  logic [SW_IDX_WIDTH-1:0]       i_sw_idx,
  input  logic [XLEN-1:0]               i_sw_data,
  output logic [NR_FLAT*XLEN-1:0]       o_eip,
  output logic [CNT_W-1:0]              o_fifo_cnt,
  output logic                          o_ovf,
  output logic [7:0]                    o_ovf_cnt,
  input  logic                          i_ovf_clr
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int DROP_W = $clog2(NR_MSI_PORTS + 1);

  typedef struct packed {
    logic [INTP_FILE_WIDTH-1:0] file;
    logic [NR_SRC_WIDTH-1:0]    id;
  } msi_ent_t;

  logic [SYNC_STAGES-1:0]  sync_r [NR_MSI_PORTS];
  logic [NR_MSI_PORTS-1:0] sync_d;
  logic [NR_MSI_PORTS-1:0] msi_edge;
  logic [NR_MSI_PORTS-1:0] acc;
  msi_ent_t                p_ent [NR_MSI_PORTS];

  msi_ent_t                fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wptr, rptr;
  logic [CNT_W-1:0]        fifo_cnt, free_slots, n_push;
  logic [DROP_W-1:0]       n_drop;
  logic [NR_MSI_PORTS-1:0] push_en;
  logic [PTR_W-1:0]        push_slot [NR_MSI_PORTS];
  msi_ent_t                head;
  logic                    pop;

  logic [8:0]              ovf_sum;
  logic                    clr_vld;
  int                      set_idx, set_bit, clr_idx, clr_bit;
  logic [XLEN-1:0]         eip_r   [NR_FLAT];
  logic [XLEN-1:0]         eip_nxt [NR_FLAT];

  for (genvar p = 0; p < NR_MSI_PORTS; p++) begin : g_port
    logic [MSI_INFO_WIDTH-1:0] info;
    logic [NR_HARTS_WIDTH-1:0] hart;
    assign info     = msi.i_msi_info[p*MSI_INFO_WIDTH +: MSI_INFO_WIDTH];
    assign hart     = info[MSI_INFO_WIDTH-1 -: NR_HARTS_WIDTH];
    assign p_ent[p] = '{file: info[NR_SRC_WIDTH +: INTP_FILE_WIDTH], id: info[NR_SRC_WIDTH-1:0]};
    assign msi_edge[p] = sync_r[p][SYNC_STAGES-1] & ~sync_d[p];
    assign acc[p] = msi_edge[p]
                  && (NR_HARTS == 1 || hart == hart_id)
                  && (32'(p_ent[p].file) < NR_INTP_FILES)
                  && (p_ent[p].id != '0)
                  && (32'(p_ent[p].id) < NR_SRC);
  end

  // Reset clears the synchroniser so a level held across reset still yields one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NR_MSI_PORTS; p++) sync_r[p] <= '0;
      sync_d <= '0;
    end else begin
      for (int p = 0; p < NR_MSI_PORTS; p++) begin
        sync_r[p] <= {sync_r[p][SYNC_STAGES-2:0], msi.i_msi_info_vld[p]};
        sync_d[p] <= sync_r[p][SYNC_STAGES-1];
      end
    end
  end

  // Same-cycle pops are not credited, so free space is judged on the start-of-cycle count.
  always_comb begin
    free_slots = CNT_W'(FIFO_DEPTH) - fifo_cnt;
    n_push     = '0;
    n_drop     = '0;
    push_en    = '0;
    for (int p = 0; p < NR_MSI_PORTS; p++) push_slot[p] = '0;
    for (int p = 0; p < NR_MSI_PORTS; p++) begin
      if (acc[p]) begin
        if (n_push < free_slots) begin
          push_en[p]   = 1'b1;
          push_slot[p] = wptr + n_push[PTR_W-1:0];
          n_push       = n_push + CNT_W'(1);
        end else begin
          n_drop = n_drop + DROP_W'(1);
        end
      end
    end
  end

  assign head = fifo_mem[rptr];
  assign pop  = (fifo_cnt != '0) && !i_eip_hold;

  always_ff @(posedge clk) begin
    for (int p = 0; p < NR_MSI_PORTS; p++) begin
      if (push_en[p]) fifo_mem[push_slot[p]] <= p_ent[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
    end else begin
      wptr     <= wptr + n_push[PTR_W-1:0];
      rptr     <= rptr + PTR_W'(pop);
      fifo_cnt <= fifo_cnt + n_push - CNT_W'(pop);
    end
  end

  // A clear coinciding with drops restarts the count from this cycle's drops.
  assign ovf_sum = (i_ovf_clr ? 9'd0 : {1'b0, o_ovf_cnt}) + 9'(n_drop);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_ovf     <= 1'b0;
      o_ovf_cnt <= '0;
    end else begin
      o_ovf     <= !i_ovf_clr && (o_ovf || (n_drop != '0));
      o_ovf_cnt <= ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
    end
  end

  assign clr_vld = i_claim_vld && (i_claim_id != '0)
                && (32'(i_claim_file) < NR_INTP_FILES) && (32'(i_claim_id) < NR_SRC);

  // Order matters: software write, then claim clear, then set so a pop beats a claim.
  always_comb begin
    set_idx = int'(head.file) * NR_REG + int'(head.id) / XLEN;
    set_bit = int'(head.id) % XLEN;
    clr_idx = int'(i_claim_file) * NR_REG + int'(i_claim_id) / XLEN;
    clr_bit = int'(i_claim_id) % XLEN;
    for (int r = 0; r < NR_FLAT; r++) begin
      eip_nxt[r] = eip_r[r];
      if (i_sw_wr && int'(i_sw_idx) == r) eip_nxt[r] = i_sw_data;
      if (clr_vld && clr_idx == r)        eip_nxt[r] = eip_nxt[r] & ~(XLEN'(1) << clr_bit);
      if (pop && set_idx == r)            eip_nxt[r] = eip_nxt[r] | (XLEN'(1) << set_bit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NR_FLAT; r++) eip_r[r] <= '0;
    end else begin
      for (int r = 0; r < NR_FLAT; r++) eip_r[r] <= eip_nxt[r];
    end
  end

  for (genvar r = 0; r < NR_FLAT; r++) begin : g_eip_out
    assign o_eip[r*XLEN +: XLEN] = eip_r[r];
  end

  assign o_fifo_cnt = fifo_cnt;
endmodule

// File: tb/tb_imsic_msi_eip_ctrl.sv
// Directed bench for imsic_msi_eip_ctrl: hand-computed eip, FIFO count and overflow expectations.
module tb_imsic_msi_eip_ctrl;
  localparam int XLEN    = 64;
  localparam int NR_FLAT = 28;
  localparam int EIP_W   = NR_FLAT * XLEN;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       hart_id;
  logic             i_eip_hold;
  logic             i_claim_vld;
  logic [2:0]       i_claim_file;
  logic [7:0]       i_claim_id;
  logic             i_sw_wr;
  logic [4:0]       i_sw_idx;
  logic [63:0]      i_sw_data;
  logic [EIP_W-1:0] o_eip;
  logic [2:0]       o_fifo_cnt;
  logic             o_ovf;
  logic [7:0]       o_ovf_cnt;
  logic             i_ovf_clr;
  logic [EIP_W-1:0] exp_v;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  imsic_msi_eip_ctrl_if #(.NR_MSI_PORTS(2), .MSI_INFO_WIDTH(13)) msi_if ();

  imsic_msi_eip_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .hart_id      (hart_id),
    .msi          (msi_if),
    .i_eip_hold   (i_eip_hold),
    .i_claim_vld  (i_claim_vld),
    .i_claim_file (i_claim_file),
    .i_claim_id   (i_claim_id),
    .i_sw_wr      (i_sw_wr),
    .i_sw_idx     (i_sw_idx),
    .i_sw_data    (i_sw_data),
    .o_eip        (o_eip),
    .o_fifo_cnt   (o_fifo_cnt),
    .o_ovf        (o_ovf),
    .o_ovf_cnt    (o_ovf_cnt),
    .i_ovf_clr    (i_ovf_clr)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [63:0] reg_of(input int r);
    return o_eip[r*XLEN +: XLEN];
  endfunction

  function automatic logic [12:0] mk(input logic [1:0] h, input logic [2:0] f, input logic [7:0] id);
    return {h, f, id};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fire(input logic [12:0] a, input logic va, input logic [12:0] b, input logic vb);
    msi_if.i_msi_info     = {b, a};
    msi_if.i_msi_info_vld = {vb, va};
  endtask

  task automatic idle();
    msi_if.i_msi_info_vld = 2'b00;
    wait_cyc(4);
  endtask

  initial begin
    rst = 1'b1; hart_id = 2'd2; i_eip_hold = 1'b0; i_claim_vld = 1'b0;
    i_claim_file = '0; i_claim_id = '0; i_sw_wr = 1'b0; i_sw_idx = '0;
    i_sw_data = '0; i_ovf_clr = 1'b0;
    msi_if.i_msi_info = '0; msi_if.i_msi_info_vld = '0;
    wait_cyc(3);
    check("rst_eip_zero", 64'(o_eip == '0), 64'd1);
    check("rst_fifo_cnt", 64'(o_fifo_cnt), 64'd0);
    check("rst_ovf", 64'(o_ovf), 64'd0);
    check("rst_ovf_cnt", 64'(o_ovf_cnt), 64'd0);
    rst = 1'b0;
    wait_cyc(2);

    // Single MSI: file 1 id 70 -> reg 5 bit 6
    fire(mk(2'd2, 3'd1, 8'd70), 1'b1, '0, 1'b0);
    wait_cyc(3);
    check("t1_cnt_e1", 64'(o_fifo_cnt), 64'd1);
    check("t1_reg5_e1", reg_of(5), 64'h0);
    wait_cyc(1);
    check("t1_reg5_e2", reg_of(5), 64'h40);
    exp_v = '0; exp_v[5*XLEN + 6] = 1'b1;
    check("t1_single_bit", 64'(o_eip == exp_v), 64'd1);
    check("t1_cnt_drained", 64'(o_fifo_cnt), 64'd0);
    idle();

    // Dual-port edge: ids 5 and 9 drain on consecutive cycles
    fire(mk(2'd2, 3'd0, 8'd5), 1'b1, mk(2'd2, 3'd0, 8'd9), 1'b1);
    wait_cyc(3);
    check("t2_cnt_two", 64'(o_fifo_cnt), 64'd2);
    check("t2_reg0_e1", reg_of(0), 64'h0);
    wait_cyc(1);
    check("t2_reg0_e2", reg_of(0), 64'h20);
    check("t2_cnt_one", 64'(o_fifo_cnt), 64'd1);
    wait_cyc(1);
    check("t2_reg0_e3", reg_of(0), 64'h220);
    check("t2_cnt_zero", 64'(o_fifo_cnt), 64'd0);
    idle();

    // Hold with three dual edges: fill to 4, drop ids 5,6
    i_eip_hold = 1'b1;
    fire(mk(2'd2, 3'd0, 8'd1), 1'b1, mk(2'd2, 3'd0, 8'd2), 1'b1);
    wait_cyc(4);
    check("t3_cnt_2", 64'(o_fifo_cnt), 64'd2);
    idle();
    fire(mk(2'd2, 3'd0, 8'd3), 1'b1, mk(2'd2, 3'd0, 8'd4), 1'b1);
    wait_cyc(4);
    check("t3_cnt_full", 64'(o_fifo_cnt), 64'd4);
    check("t3_no_ovf_at_full", 64'(o_ovf), 64'd0);
    idle();
    fire(mk(2'd2, 3'd0, 8'd5), 1'b1, mk(2'd2, 3'd0, 8'd6), 1'b1);
    wait_cyc(4);
    check("t3_cnt_capped", 64'(o_fifo_cnt), 64'd4);
    check("t3_ovf", 64'(o_ovf), 64'd1);
    check("t3_ovf_cnt", 64'(o_ovf_cnt), 64'd2);
    idle();

    // 127 more dual drops: 2 + 254 = 256 saturates at 255
    for (int i = 0; i < 127; i++) begin
      fire(mk(2'd2, 3'd0, 8'd7), 1'b1, mk(2'd2, 3'd0, 8'd8), 1'b1);
      wait_cyc(4);
      idle();
    end
    check("t3_ovf_cnt_sat", 64'(o_ovf_cnt), 64'd255);
    check("t3_cnt_still_full", 64'(o_fifo_cnt), 64'd4);

    // Clear coinciding with a 2-MSI drop
    fire(mk(2'd2, 3'd0, 8'd7), 1'b1, mk(2'd2, 3'd0, 8'd8), 1'b1);
    wait_cyc(2);
    i_ovf_clr = 1'b1;
    wait_cyc(1);
    i_ovf_clr = 1'b0;
    check("t3_clr_drop_ovf", 64'(o_ovf), 64'd0);
    check("t3_clr_drop_cnt", 64'(o_ovf_cnt), 64'd2);
    idle();
    i_ovf_clr = 1'b1;
    wait_cyc(1);
    i_ovf_clr = 1'b0;
    check("t3_clr_cnt", 64'(o_ovf_cnt), 64'd0);

    // Release hold: ids 1..4 drain one per cycle
    i_eip_hold = 1'b0;
    wait_cyc(1);
    check("t3_drain_1", reg_of(0), 64'h222);
    check("t3_drain_cnt3", 64'(o_fifo_cnt), 64'd3);
    wait_cyc(1);
    check("t3_drain_2", reg_of(0), 64'h226);
    wait_cyc(2);
    check("t3_drain_all", reg_of(0), 64'h23E);
    check("t3_drain_cnt0", 64'(o_fifo_cnt), 64'd0);

    // Claim and pop of the same bit in one cycle, then claim alone
    fire(mk(2'd2, 3'd0, 8'd3), 1'b1, '0, 1'b0);
    wait_cyc(3);
    i_claim_vld = 1'b1; i_claim_file = 3'd0; i_claim_id = 8'd3;
    wait_cyc(1);
    check("t4_set_beats_clr", reg_of(0), 64'h23E);
    wait_cyc(1);
    check("t4_claim_clears", reg_of(0), 64'h236);
    i_claim_vld = 1'b0;
    idle();

    // Software write then write racing a pop
    i_sw_wr = 1'b1; i_sw_idx = 5'd0; i_sw_data = 64'hFF;
    wait_cyc(1);
    i_sw_wr = 1'b0;
    check("t5_sw_ff", reg_of(0), 64'hFF);
    fire(mk(2'd2, 3'd0, 8'd3), 1'b1, '0, 1'b0);
    wait_cyc(3);
    i_sw_wr = 1'b1; i_sw_idx = 5'd0; i_sw_data = 64'h0;
    wait_cyc(1);
    i_sw_wr = 1'b0;
    check("t5_sw_then_set", reg_of(0), 64'h08);
    idle();
    i_sw_wr = 1'b1; i_sw_idx = 5'd5; i_sw_data = 64'hABCD;
    wait_cyc(1);
    i_sw_wr = 1'b0;
    check("t5_sw_reg5", reg_of(5), 64'hABCD);
    i_sw_wr = 1'b1; i_sw_idx = 5'd0; i_sw_data = 64'h09;
    wait_cyc(1);
    i_sw_wr = 1'b0;
    i_claim_vld = 1'b1; i_claim_file = 3'd0; i_claim_id = 8'd0;
    wait_cyc(1);
    check("t5_claim_id0_ignored", reg_of(0), 64'h09);
    i_claim_file = 3'd7; i_claim_id = 8'd3;
    wait_cyc(1);
    i_claim_vld = 1'b0;
    check("t5_claim_file7_ignored", reg_of(0), 64'h09);

    // Rejected MSIs: wrong hart, id 0, file 7
    fire(mk(2'd1, 3'd0, 8'd5), 1'b1, mk(2'd2, 3'd0, 8'd0), 1'b1);
    wait_cyc(4);
    check("t6_rej_cnt_a", 64'(o_fifo_cnt), 64'd0);
    idle();
    fire(mk(2'd2, 3'd7, 8'd5), 1'b1, '0, 1'b0);
    wait_cyc(4);
    check("t6_rej_cnt_b", 64'(o_fifo_cnt), 64'd0);
    check("t6_rej_ovf", 64'(o_ovf), 64'd0);
    check("t6_rej_reg0", reg_of(0), 64'h09);
    check("t6_rej_reg5", reg_of(5), 64'hABCD);
    idle();

    // Valid level held across reset yields exactly one MSI
    fire(mk(2'd2, 3'd0, 8'd10), 1'b1, '0, 1'b0);
    wait_cyc(1);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    check("t7_rst_clears_eip", 64'(o_eip == '0), 64'd1);
    wait_cyc(4);
    check("t7_one_edge_reg0", reg_of(0), 64'h400);
    exp_v = '0; exp_v[10] = 1'b1;
    check("t7_only_bit", 64'(o_eip == exp_v), 64'd1);
    wait_cyc(4);
    check("t7_no_second_push", 64'(o_fifo_cnt), 64'd0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
